// File: rtl/cv32e40p_rf_scrubber.sv
// Background parity scrubber for the parity-protected register file.
// Define CV32E40P_RF_SCRUB_FP_EN to extend the sweep over the FP bank (0..63).
module cv32e40p_rf_scrubber #(
    parameter int unsigned SCRUB_INTERVAL = 64,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scrub_en_i,
    output logic                  scrub_req_o,
    input  logic                  scrub_gnt_i,
    output logic [5:0]            raddr_o,
    input  logic [DATA_WIDTH:0]   rdata_i,
    output logic                  err_valid_o,
    output logic [5:0]            err_addr_o,
    input  logic                  err_ack_i,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic                  sweep_done_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_REQ    = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

`ifdef CV32E40P_RF_SCRUB_FP_EN
    localparam int unsigned AW = 6;
`else
    localparam int unsigned AW = 5;
`endif
    localparam logic [AW-1:0] LAST_ADDR = '1;

    localparam int unsigned IW = $clog2(SCRUB_INTERVAL + 1);
    localparam logic [IW-1:0] INTERVAL_C = IW'(SCRUB_INTERVAL);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Stored parity (bit 0) must equal the XOR of the data bits.
    function automatic logic parity_ok(input logic [DATA_WIDTH:0] word);
        return word[0] == (^word[DATA_WIDTH:1]);
    endfunction

    logic [1:0]           r_state;
    logic [IW-1:0]        r_icnt;
    logic [AW-1:0]        r_addr;
    logic                 r_req;
    logic                 r_err_valid;
    logic [5:0]           r_err_addr;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic                 r_done;

    logic [1:0]           w_state_nxt;
    logic                 w_resolve;
    logic                 w_bad;
    logic [AW-1:0]        w_addr_nxt;
    logic [5:0]           w_raddr;

`ifdef CV32E40P_RF_SCRUB_FP_EN
    assign w_raddr = r_addr;
`else
    assign w_raddr = {1'b0, r_addr};
`endif

    assign w_addr_nxt = (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);

    // Next-state decode; a grant in the cycle scrubbing is disabled is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_resolve   = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (scrub_en_i) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!scrub_en_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_icnt == IW'(1)) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_REQ: begin
                if (!scrub_en_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (scrub_gnt_i) begin
                    if (parity_ok(rdata_i)) begin
                        w_resolve   = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_bad       = 1'b1;
                        w_state_nxt = ST_REPORT;
                    end
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REPORT: begin
                if (err_ack_i) begin
                    w_resolve   = 1'b1;
                    w_state_nxt = scrub_en_i ? ST_WAIT : ST_IDLE;
                end else begin
                    w_state_nxt = ST_REPORT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, interval counter, sweep address and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_icnt      <= '0;
            r_addr      <= '0;
            r_req       <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_addr  <= 6'd0;
            r_err_cnt   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_WAIT && r_state != ST_WAIT) begin
                r_icnt <= INTERVAL_C;
            end else if (r_state == ST_WAIT && r_icnt != '0) begin
                r_icnt <= r_icnt - IW'(1);
            end else begin
                r_icnt <= r_icnt;
            end
            if (w_resolve) begin
                r_addr <= w_addr_nxt;
            end else begin
                r_addr <= r_addr;
            end
            if (w_bad) begin
                r_err_addr <= w_raddr;
                r_err_cnt  <= (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + CNT_WIDTH'(1);
            end else begin
                r_err_addr <= r_err_addr;
                r_err_cnt  <= r_err_cnt;
            end
            r_req       <= (w_state_nxt == ST_REQ);
            r_err_valid <= (w_state_nxt == ST_REPORT);
            r_done      <= w_resolve && (r_addr == LAST_ADDR);
        end
    end

    assign scrub_req_o  = r_req;
    assign raddr_o      = w_raddr;
    assign err_valid_o  = r_err_valid;
    assign err_addr_o   = r_err_addr;
    assign err_cnt_o    = r_err_cnt;
    assign sweep_done_o = r_done;

endmodule

// File: tb/tb_cv32e40p_rf_scrubber.sv
// Directed self-checking bench for cv32e40p_rf_scrubber (SCRUB_INTERVAL=4, CNT_WIDTH=2).
module tb_cv32e40p_rf_scrubber;

    logic        clk;
    logic        rst_n;
    logic        scrub_en;
    logic        scrub_req;
    logic        scrub_gnt;
    logic [5:0]  raddr;
    logic [32:0] rdata;
    logic        err_valid;
    logic [5:0]  err_addr;
    logic        err_ack;
    logic [1:0]  err_cnt;
    logic        sweep_done;

    logic [32:0] mem [0:63];
    int total;
    int bad;

`ifdef CV32E40P_RF_SCRUB_FP_EN
    localparam int LAST = 63;
`else
    localparam int LAST = 31;
`endif
    localparam logic [32:0] GOOD_W = 33'h0;
    localparam logic [32:0] BAD_W  = 33'h2;

    cv32e40p_rf_scrubber #(
        .SCRUB_INTERVAL(4),
        .DATA_WIDTH(32),
        .CNT_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .scrub_en_i(scrub_en),
        .scrub_req_o(scrub_req),
        .scrub_gnt_i(scrub_gnt),
        .raddr_o(raddr),
        .rdata_i(rdata),
        .err_valid_o(err_valid),
        .err_addr_o(err_addr),
        .err_ack_i(err_ack),
        .err_cnt_o(err_cnt),
        .sweep_done_o(sweep_done)
    );

    assign rdata = mem[raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_req(output int n);
        n = 0;
        while (!scrub_req && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!scrub_req) n = -1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; scrub_en = 1'b0; scrub_gnt = 1'b0; err_ack = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = GOOD_W;
        repeat (3) @(negedge clk);
        total++;
        if ({scrub_req, raddr, err_valid, err_addr, err_cnt, sweep_done} !== 16'h0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {scrub_req, raddr, err_valid, err_addr, err_cnt, sweep_done});
        end
        rst_n = 1'b1;
        scrub_en = 1'b1;
        scrub_gnt = 1'b1;
        wait_req(n);
        total++;
        if (n !== 5) begin bad++; $display("FAIL first_req_latency got=%0d exp=5", n); end
        total++;
        if (raddr !== 6'd0) begin bad++; $display("FAIL first_req_addr got=%0d exp=0", raddr); end
        @(negedge clk);
        wait_req(n);
        total++;
        if (n + 1 !== 5) begin bad++; $display("FAIL req_spacing got=%0d exp=5", n + 1); end
        total++;
        if (raddr !== 6'd1) begin bad++; $display("FAIL second_req_addr got=%0d exp=1", raddr); end
        total++;
        if (err_valid !== 1'b0) begin bad++; $display("FAIL no_err_good got=%0d exp=0", err_valid); end
    endtask

    task automatic test_bad_word();
        int n;
        logic prev_req;
        logic [5:0] prev_addr;
        mem[7] = BAD_W;
        prev_req = scrub_req; prev_addr = raddr;
        n = 0;
        while (!err_valid && n < 300) begin
            prev_req = scrub_req; prev_addr = raddr;
            @(negedge clk);
            n++;
        end
        total++;
        if (err_valid !== 1'b1) begin bad++; $display("FAIL err_timeout got=%0d exp=1", err_valid); end
        total++;
        if (!(prev_req === 1'b1 && prev_addr === 6'd7)) begin
            bad++; $display("FAIL err_latency got=req%0d/addr%0d exp=req1/addr7", prev_req, prev_addr);
        end
        total++;
        if (err_addr !== 6'd7) begin bad++; $display("FAIL err_addr got=%0d exp=7", err_addr); end
        total++;
        if (err_cnt !== 2'd1) begin bad++; $display("FAIL err_cnt_first got=%0d exp=1", err_cnt); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (err_valid !== 1'b1 || raddr !== 6'd7 || scrub_req !== 1'b0) begin
                bad++; $display("FAIL report_hold got=v%0d/a%0d/r%0d exp=v1/a7/r0", err_valid, raddr, scrub_req);
            end
        end
        mem[7] = GOOD_W;
        err_ack = 1'b1;
        @(negedge clk);
        err_ack = 1'b0;
        total++;
        if (err_valid !== 1'b0) begin bad++; $display("FAIL err_clear got=%0d exp=0", err_valid); end
        wait_req(n);
        total++;
        if (n !== 4) begin bad++; $display("FAIL post_ack_latency got=%0d exp=4", n); end
        total++;
        if (raddr !== 6'd8) begin bad++; $display("FAIL post_ack_addr got=%0d exp=8", raddr); end
    endtask

    task automatic test_grant_withheld();
        scrub_gnt = 1'b0;
        mem[8] = BAD_W;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (scrub_req !== 1'b1 || raddr !== 6'd8 || err_valid !== 1'b0) begin
                bad++; $display("FAIL withheld_hold got=r%0d/a%0d/v%0d exp=r1/a8/v0", scrub_req, raddr, err_valid);
            end
        end
        mem[8] = GOOD_W;
        scrub_gnt = 1'b1;
        @(negedge clk);
        total++;
        if (scrub_req !== 1'b0 || raddr !== 6'd9 || err_valid !== 1'b0) begin
            bad++; $display("FAIL withheld_release got=r%0d/a%0d/v%0d exp=r0/a9/v0", scrub_req, raddr, err_valid);
        end
    endtask

    task automatic test_full_sweep();
        int dones;
        int lastreq;
        bit seen0;
        dones = 0; lastreq = -1; seen0 = 1'b0;
        for (int i = 0; i < 2000 && !seen0; i++) begin
            @(negedge clk);
            if (sweep_done) begin
                dones++;
                total++;
                if (lastreq !== LAST || raddr !== 6'd0) begin
                    bad++; $display("FAIL sweep_done_point got=last%0d/a%0d exp=last%0d/a0", lastreq, raddr, LAST);
                end
            end
            if (scrub_req) begin
                if (dones > 0 && raddr == 6'd0) seen0 = 1'b1;
                lastreq = raddr;
            end
        end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL sweep_done_count got=%0d exp=1", dones); end
        total++;
        if (seen0 !== 1'b1) begin bad++; $display("FAIL sweep_wrap got=%0d exp=1", seen0); end
    endtask

    task automatic test_disable();
        int n;
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            wait_req(n);
            if (raddr == 6'd11 || n < 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        total++;
        if (raddr !== 6'd12 || scrub_req !== 1'b0) begin
            bad++; $display("FAIL disable_point got=a%0d/r%0d exp=a12/r0", raddr, scrub_req);
        end
        scrub_en = 1'b0;
        scrub_gnt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (scrub_req !== 1'b0 || raddr !== 6'd12) begin
                bad++; $display("FAIL disabled_idle got=r%0d/a%0d exp=r0/a12", scrub_req, raddr);
            end
        end
        scrub_en = 1'b1;
        wait_req(n);
        total++;
        if (n !== 5 || raddr !== 6'd12) begin bad++; $display("FAIL reenable got=n%0d/a%0d exp=n5/a12", n, raddr); end
        mem[12] = BAD_W;
        scrub_gnt = 1'b1;
        scrub_en = 1'b0;
        @(negedge clk);
        total++;
        if (scrub_req !== 1'b0 || err_valid !== 1'b0 || raddr !== 6'd12) begin
            bad++; $display("FAIL disable_in_req got=r%0d/v%0d/a%0d exp=r0/v0/a12", scrub_req, err_valid, raddr);
        end
        mem[12] = GOOD_W;
        scrub_en = 1'b1;
        wait_req(n);
        total++;
        if (n !== 5 || raddr !== 6'd12) begin bad++; $display("FAIL resume_after_req got=n%0d/a%0d exp=n5/a12", n, raddr); end
    endtask

    task automatic test_saturate();
        int errs;
        int exp_cnt;
        logic prev_v;
        errs = 0; prev_v = 1'b0;
        err_ack = 1'b1;
        for (int a = 13; a <= 17; a++) mem[a] = BAD_W;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (err_valid) begin
                errs++;
                exp_cnt = (1 + errs > 3) ? 3 : 1 + errs;
                total++;
                if (err_cnt !== exp_cnt[1:0] || err_addr !== 6'(12 + errs) || prev_v) begin
                    bad++; $display("FAIL saturate_report got=c%0d/a%0d/p%0d exp=c%0d/a%0d/p0", err_cnt, err_addr, prev_v, exp_cnt, 12 + errs);
                end
            end
            prev_v = err_valid;
            if (scrub_req && raddr == 6'd18) break;
        end
        for (int a = 13; a <= 17; a++) mem[a] = GOOD_W;
        total++;
        if (errs !== 5) begin bad++; $display("FAIL saturate_count got=%0d exp=5", errs); end
        total++;
        if (err_cnt !== 2'd3) begin bad++; $display("FAIL saturate_hold got=%0d exp=3", err_cnt); end
        err_ack = 1'b0;
    endtask

    task automatic test_reset_in_report();
        int n;
        mem[20] = BAD_W;
        n = 0;
        while (!err_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (err_valid !== 1'b1 || err_addr !== 6'd20) begin
            bad++; $display("FAIL pre_reset_report got=v%0d/a%0d exp=v1/a20", err_valid, err_addr);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({scrub_req, raddr, err_valid, err_addr, err_cnt, sweep_done} !== 16'h0) begin
            bad++; $display("FAIL reset_in_report got=%h exp=0", {scrub_req, raddr, err_valid, err_addr, err_cnt, sweep_done});
        end
        mem[20] = GOOD_W;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_bad_word();
        test_grant_withheld();
        test_full_sweep();
        test_disable();
        test_saturate();
        test_reset_in_report();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40p_rf_scrubber.md
# cv32e40p_rf_scrubber

Background parity scrubber for the parity-protected register file. It periodically borrows a spare read port, sweeps every stored word, and recomputes parity over the data bits. On a mismatch it reports the failing address and keeps a saturating error count. It sits beside the register file in the ID stage, and the controller arbitrates its read requests against core traffic.

## Interface
- `SCRUB_INTERVAL`, 64: idle cycles between consecutive scrub reads; legal range is ≥1.
- `DATA_WIDTH`, 32: data bits per register word; the stored word is DATA_WIDTH+1 bits.
- `CNT_WIDTH`, 8: width of the error counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `scrub_en_i` in 1: enables sweeping.
- `scrub_req_o` out 1: request for the spare read port.
- `scrub_gnt_i` in 1: port granted this cycle.
- `raddr_o` out 6: read address; bit 5 selects the FP bank.
- `rdata_i` in DATA_WIDTH+1: raw stored word. Bit 0 is stored parity; bits DATA_WIDTH:1 are data. Combinationally valid in the same cycle as `raddr_o`.
- `err_valid_o` out 1: a parity error report is pending.
- `err_addr_o` out 6: address of the failing word.
- `err_ack_i` in 1: acknowledges the pending report.
- `err_cnt_o` out CNT_WIDTH: total errors found, saturating.
- `sweep_done_o` out 1: one-cycle pulse when the last address has been checked.

## Operation
- Parity rule: the word is good when `rdata_i[0]` equals the XOR of `rdata_i[DATA_WIDTH:1]`. Address 0 is checked like any other word; the all-zero word is good.
- States:
  - IDLE: entered from reset, or when `scrub_en_i`=0. Moves to WAIT when `scrub_en_i`=1.
  - WAIT: loads the interval counter with SCRUB_INTERVAL on entry and decrements it each cycle. Moves to REQ in the cycle after the counter reaches 1, giving exactly SCRUB_INTERVAL cycles in WAIT.
  - REQ: drives `scrub_req_o`=1 and holds `raddr_o` stable. On the edge where `scrub_gnt_i`=1, samples `rdata_i` and evaluates parity:
    - Good word: advance the address and go to WAIT.
    - Bad word: go to REPORT.
  - REPORT: drives `err_valid_o`=1 and holds `err_addr_o`. On `err_ack_i`=1: clear `err_valid_o`, advance the address, go to WAIT.
- `err_cnt_o` increments on the bad-word edge in REQ and saturates at all ones.
- Address sweep:
  - The address advances by 1 and wraps from the last address to 0.
  - `sweep_done_o` pulses in the cycle after the last address is resolved, whether good or acknowledged.
- Disable:
  - `scrub_en_i`=0 in WAIT or REQ moves to IDLE at the next edge.
  - The current address is retained, so the sweep resumes where it stopped.
  - A grant in that same cycle is ignored.
  - In REPORT, disable has no effect until the report is acknowledged; after ack the FSM goes to IDLE.
- `err_ack_i` outside REPORT is ignored.
- `scrub_gnt_i` outside REQ is ignored.

## Timing
- Reset values: `scrub_req_o`=0, `raddr_o`=0, `err_valid_o`=0, `err_addr_o`=0, `err_cnt_o`=0, `sweep_done_o`=0, state IDLE, interval counter 0.
- Reset asserted mid-operation, including in REPORT, clears everything immediately. A pending report is lost.
- All outputs are registered; no output is combinational from any input.
- Minimum spacing between grants is SCRUB_INTERVAL+1 cycles. This is also the spacing with an immediate grant.
- Bad word:
  - `err_valid_o` and the new `err_cnt_o` are visible in the cycle after the grant edge.
  - A same-cycle `err_ack_i` at the first REPORT cycle is accepted, so REPORT lasts one cycle.
- Simultaneous bad word and counter at maximum: the counter holds at maximum and the report is still raised.

## Configuration
- `CV32E40P_RF_SCRUB_FP_EN` defined:
  - The sweep covers addresses 0..63 (integer and FP banks).
  - The last address is 63.
- Not defined:
  - The sweep covers 0..31.
  - The last address is 31.
  - `raddr_o[5]` is tied to 0.
  - Port widths are unchanged.

## Test plan
- Reset, with SCRUB_INTERVAL=4, `scrub_en_i`=1, grant always 1, all words good:
  - Expect exactly 4 WAIT cycles, then `scrub_req_o`=1 with `raddr_o`=0.
  - Expect the next request 5 cycles later with `raddr_o`=1.
  - Expect no `err_valid_o`.
- Word 7 stored as data 0x00000001 with parity 0:
  - Expect `err_valid_o`=1, `err_addr_o`=7, `err_cnt_o`=1.
  - Hold ack low 10 cycles: `err_valid_o` stays 1 and `raddr_o` stays 7.
  - After ack, the next request is for address 8.
- Grant withheld 20 cycles in REQ: `scrub_req_o` and `raddr_o` stay stable; no sampling occurs.
- Full sweep with the macro undefined: `sweep_done_o` pulses once after address 31 and `raddr_o` wraps to 0. With the macro defined, the same holds after address 63.
- Disable at address 12 in WAIT:
  - Expect IDLE next cycle and `scrub_req_o`=0.
  - On re-enable, the first request is for address 12.
- CNT_WIDTH=2 with 5 corrupted words: `err_cnt_o` reaches 3 and holds.
- Assert `rst_n`=0 in REPORT: all outputs are at reset values immediately.
